// File: rtl/iomem_router_pkg.sv
// iomem_router_pkg: shared types and constants for the memory-bus router.
package iomem_router_pkg;

  localparam int          TO_W      = 16;
  localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Request fields latched on accept and presented to every slave.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  // Width of a slave index; at least one bit so NSLV=1 still has a select.
  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iomem_router_dec.sv
// iomem_router_dec: combinational window decoder. Every slave window is
// compared in parallel; the lowest-index hit wins when windows overlap.
module iomem_router_dec
  import iomem_router_pkg::*;
#(
  parameter int                NSLV     = 4,
  parameter int                SW       = sel_w(NSLV),
  parameter logic [32*NSLV-1:0] SLV_BASE = {NSLV{32'h0}},
  parameter logic [32*NSLV-1:0] SLV_MASK = {NSLV{32'hFF00_0000}}
) (
  input  logic [31:0]   addr,
  output logic          hit,
  output logic [SW-1:0] sel
);

  logic [NSLV-1:0] win;

  for (genvar i = 0; i < NSLV; i++) begin : g_win
    assign win[i] = (addr & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32];
  end

  // Priority select: scan high to low so the lowest hit is written last.
  always_comb begin
    hit = |win;
    sel = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if (win[i]) sel = SW'(i);
    end
  end

endmodule

// File: rtl/iomem_router.sv
// iomem_router: routes core valid/ready requests to one of NSLV slaves,
// returns a registered one-cycle response, and captures sticky errors.
// Optional feature: define IOMEM_ROUTER_TIMEOUT_EN to abort slaves that
// stay unready for TIMEOUT cycles (response data ERR_RDATA, error logged).
module iomem_router
  import iomem_router_pkg::*;
#(
  parameter int                 NSLV     = 4,
  parameter logic [32*NSLV-1:0] SLV_BASE = {NSLV{32'h0}},
  parameter logic [32*NSLV-1:0] SLV_MASK = {NSLV{32'hFF00_0000}},
  parameter int                 TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_rdata,
  output logic [NSLV-1:0]   s_valid,
  input  logic [NSLV-1:0]   s_ready,
  output logic [31:0]       s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wstrb,
  input  logic [32*NSLV-1:0] s_rdata,
  output logic              err_flag,
  output logic [31:0]       err_addr,
  input  logic              err_clr
);

  localparam int SW = sel_w(NSLV);

  if (NSLV < 1 || NSLV > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("iomem_router: NSLV or TIMEOUT out of range");
  end

  state_t        state, state_nx;
  req_t          req_q;
  logic [SW-1:0] sel, dec_sel;
  logic          dec_hit;
  logic          load_req, unmapped, cap, to_fire;
  logic [31:0]   slv_rd [NSLV];

  for (genvar i = 0; i < NSLV; i++) begin : g_rd
    assign slv_rd[i] = s_rdata[32*i +: 32];
  end

  iomem_router_dec #(
    .NSLV     (NSLV),
    .SW       (SW),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_dec (
    .addr (mem_addr),
    .hit  (dec_hit),
    .sel  (dec_sel)
  );

`ifdef IOMEM_ROUTER_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt;

  // Wait counter: zero outside REQ, so it reads 0 on the first REQ cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              to_cnt <= '0;
    else if (state != REQ)  to_cnt <= '0;
    else                    to_cnt <= to_cnt + TO_W'(1);
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state and per-cycle action strobes; slave ready beats timeout.
  always_comb begin
    state_nx = state;
    load_req = 1'b0;
    unmapped = 1'b0;
    cap      = 1'b0;
    to_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (mem_valid) begin
          if (dec_hit) begin
            load_req = 1'b1;
            state_nx = REQ;
          end else begin
            unmapped = 1'b1;
            state_nx = RESP;
          end
        end
      end
      REQ: begin
        if (s_ready[sel]) begin
          cap      = 1'b1;
          state_nx = RESP;
        end
`ifdef IOMEM_ROUTER_TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          to_fire  = 1'b1;
          state_nx = RESP;
        end
`endif
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Latch request fields and the decoded slave on accept only.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_q <= '0;
      sel   <= '0;
    end else if (load_req) begin
      req_q <= '{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb};
      sel   <= dec_sel;
    end
  end

  // Response data: zero for unmapped, slave data on ready, all-ones on abort.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)         mem_rdata <= '0;
    else if (unmapped) mem_rdata <= '0;
    else if (cap)      mem_rdata <= slv_rd[sel];
    else if (to_fire)  mem_rdata <= ERR_RDATA;
  end

  // Sticky error capture; a new error outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_flag <= 1'b0;
      err_addr <= '0;
    end else if (unmapped) begin
      err_flag <= 1'b1;
      err_addr <= mem_addr;
    end else if (to_fire) begin
      err_flag <= 1'b1;
      err_addr <= req_q.addr;
    end else if (err_clr) begin
      err_flag <= 1'b0;
    end
  end

  // Slave strobe decoded from registered state so reset kills it at once.
  always_comb begin
    s_valid = '0;
    if (state == REQ) s_valid[sel] = 1'b1;
  end

  assign mem_ready = (state == RESP);
  assign s_addr    = req_q.addr;
  assign s_wdata   = req_q.wdata;
  assign s_wstrb   = req_q.wstrb;

endmodule

// File: tb/tb_iomem_router.sv
// tb_iomem_router: scoreboard bench for iomem_router. Slave 3 shadows slave 1
// to exercise overlapping windows; 0x05/0x07 regions are unmapped.
module tb_iomem_router;

  logic         clk = 1'b0;
  logic         rstn;
  logic         mem_valid;
  logic         mem_ready;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;
  logic [3:0]   mem_wstrb;
  logic [3:0]   s_valid, s_ready;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_wstrb;
  logic [127:0] s_rdata;
  logic         err_flag, err_clr;
  logic [31:0]  err_addr;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb [$];

  // Slave model: ready after wait_cfg[i] wait cycles; force_rdy drives ready unconditionally.
  int          wait_cfg [4];
  int          wcnt     [4];
  logic [3:0]  force_rdy;
  logic [31:0] slv_data [4];

  always #5 clk = ~clk;

  iomem_router #(
    .NSLV     (4),
    .SLV_BASE ({32'h0100_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000}),
    .SLV_MASK ({4{32'hFF00_0000}}),
    .TIMEOUT  (8)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_rdata (mem_rdata),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_addr    (s_addr),
    .s_wdata   (s_wdata),
    .s_wstrb   (s_wstrb),
    .s_rdata   (s_rdata),
    .err_flag  (err_flag),
    .err_addr  (err_addr),
    .err_clr   (err_clr)
  );

  always_comb begin
    s_ready = force_rdy;
    s_rdata = '0;
    for (int i = 0; i < 4; i++) begin
      if (s_valid[i] && wcnt[i] == wait_cfg[i]) s_ready[i] = 1'b1;
      s_rdata[32*i +: 32] = slv_data[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (s_valid[i] && !s_ready[i]) wcnt[i] <= wcnt[i] + 1;
      else                           wcnt[i] <= 0;
    end
  end

  task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    mem_valid = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = st;
  endtask

  // Waits (bounded) for mem_ready; lat counts cycles after the accept cycle.
  // After the accept edge the core drops valid and scribbles on the address.
  task automatic wait_resp(output int lat, output logic [3:0] sv_first, output int sv_cyc);
    lat = -1; sv_first = '0; sv_cyc = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (c == 1) begin
        sv_first  = s_valid;
        mem_valid = 1'b0;
        mem_addr  = 32'hDEAD_BEEF;
        err_clr   = 1'b0;
      end
      if (s_valid != 4'b0) sv_cyc++;
      if (mem_ready) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready got %b want 0", mem_ready); end
    checks++; if (s_valid !== 4'b0) begin errors++; $display("FAIL reset_s_valid got %b want 0000", s_valid); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_mem_rdata got %h want 0", mem_rdata); end
    checks++; if ({s_addr, s_wdata, s_wstrb} !== 68'h0) begin errors++; $display("FAIL reset_s_bus got %h/%h/%h want 0", s_addr, s_wdata, s_wstrb); end
    checks++; if (err_flag !== 1'b0 || err_addr !== 32'h0) begin errors++; $display("FAIL reset_err got %b/%h want 0/0", err_flag, err_addr); end
  endtask

  task automatic test_read;
    int lat, cyc; logic [3:0] sv; logic [31:0] exp;
    slv_data[0] = 32'h1234_5678;
    @(negedge clk);
    drive_req(32'h0000_0010, 32'h0, 4'h0);
    sb.push_back(32'h1234_5678);
    wait_resp(lat, sv, cyc);
    checks++; if (sv !== 4'b0001) begin errors++; $display("FAIL read_s_valid got %b want 0001", sv); end
    checks++; if (lat != 2) begin errors++; $display("FAIL read_latency got %0d want 2", lat); end
    exp = sb.pop_front();
    checks++; if (mem_rdata !== exp) begin errors++; $display("FAIL read_rdata got %h want %h", mem_rdata, exp); end
    checks++; if (s_addr !== 32'h0000_0010) begin errors++; $display("FAIL read_s_addr got %h want 00000010", s_addr); end
    @(negedge clk);
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL read_pulse got %b want 0", mem_ready); end
    checks++; if (mem_rdata !== exp) begin errors++; $display("FAIL read_hold got %h want %h", mem_rdata, exp); end
  endtask

  task automatic test_write;
    int lat, cyc; logic [3:0] sv; logic [31:0] exp;
    wait_cfg[2] = 3;
    force_rdy   = 4'b0001;  // stray ready on an unselected slave must be ignored
    drive_req(32'h0200_0008, 32'h0000_00A5, 4'b0001);
    sb.push_back(slv_data[2]);
    wait_resp(lat, sv, cyc);
    checks++; if (sv !== 4'b0100) begin errors++; $display("FAIL write_s_valid got %b want 0100", sv); end
    checks++; if (lat != 5 || cyc != 4) begin errors++; $display("FAIL write_latency got %0d/%0d want 5/4", lat, cyc); end
    checks++; if (s_wdata !== 32'hA5 || s_wstrb !== 4'b0001) begin errors++; $display("FAIL write_latch got %h/%b want a5/0001", s_wdata, s_wstrb); end
    exp = sb.pop_front();
    checks++; if (mem_rdata !== exp) begin errors++; $display("FAIL write_rdata got %h want %h", mem_rdata, exp); end
    @(negedge clk);
    checks++; if (mem_ready !== 1'b0) begin errors++; $display("FAIL write_pulse got %b want 0", mem_ready); end
    force_rdy   = 4'b0;
    wait_cfg[2] = 0;
  endtask

  task automatic test_unmapped;
    int lat, cyc; logic [3:0] sv; logic [31:0] exp;
    drive_req(32'h0500_0000, 32'h0, 4'h0);
    sb.push_back(32'h0);
    wait_resp(lat, sv, cyc);
    checks++; if (lat != 1 || cyc != 0) begin errors++; $display("FAIL unmap_latency got %0d/%0d want 1/0", lat, cyc); end
    exp = sb.pop_front();
    checks++; if (mem_rdata !== exp) begin errors++; $display("FAIL unmap_rdata got %h want %h", mem_rdata, exp); end
    checks++; if (err_flag !== 1'b1 || err_addr !== 32'h0500_0000) begin errors++; $display("FAIL unmap_err got %b/%h want 1/05000000", err_flag, err_addr); end
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL unmap_clr got %b want 0", err_flag); end
    // Clear coincides with a new unmapped accept: the error must win.
    drive_req(32'h0700_0000, 32'h0, 4'h0);
    err_clr = 1'b1;
    sb.push_back(32'h0);
    wait_resp(lat, sv, cyc);
    exp = sb.pop_front();
    checks++; if (lat != 1 || mem_rdata !== exp) begin errors++; $display("FAIL unmap2_resp got %0d/%h want 1/%h", lat, mem_rdata, exp); end
    checks++; if (err_flag !== 1'b1 || err_addr !== 32'h0700_0000) begin errors++; $display("FAIL clr_vs_err got %b/%h want 1/07000000", err_flag, err_addr); end
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_timeout;
    int lat, cyc; logic [3:0] sv; logic [31:0] exp;
`ifdef IOMEM_ROUTER_TIMEOUT_EN
    wait_cfg[0] = 1000;
    drive_req(32'h0000_0100, 32'h0, 4'h0);
    sb.push_back(32'hFFFF_FFFF);
    wait_resp(lat, sv, cyc);
    checks++; if (lat != 9 || cyc != 8) begin errors++; $display("FAIL to_latency got %0d/%0d want 9/8", lat, cyc); end
    exp = sb.pop_front();
    checks++; if (mem_rdata !== exp) begin errors++; $display("FAIL to_rdata got %h want %h", mem_rdata, exp); end
    checks++; if (err_flag !== 1'b1 || err_addr !== 32'h0000_0100) begin errors++; $display("FAIL to_err got %b/%h want 1/00000100", err_flag, err_addr); end
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    // Ready on the last allowed cycle beats the abort.
    wait_cfg[0] = 7;
    slv_data[0] = 32'h0BAD_F00D;
    drive_req(32'h0000_0200, 32'h0, 4'h0);
    sb.push_back(32'h0BAD_F00D);
    wait_resp(lat, sv, cyc);
    exp = sb.pop_front();
    checks++; if (lat != 9 || mem_rdata !== exp) begin errors++; $display("FAIL to_edge got %0d/%h want 9/%h", lat, mem_rdata, exp); end
    checks++; if (err_flag !== 1'b0) begin errors++; $display("FAIL to_edge_err got %b want 0", err_flag); end
`else
    // Without the timeout feature a slow slave is simply waited for.
    wait_cfg[0] = 20;
    slv_data[0] = 32'h0BAD_F00D;
    drive_req(32'h0000_0200, 32'h0, 4'h0);
    sb.push_back(32'h0BAD_F00D);
    wait_resp(lat, sv, cyc);
    exp = sb.pop_front();
    checks++; if (lat != 22 || cyc != 21) begin errors++; $display("FAIL slow_latency got %0d/%0d want 22/21", lat, cyc); end
    checks++; if (mem_rdata !== exp || err_flag !== 1'b0) begin errors++; $display("FAIL slow_resp got %h/%b want %h/0", mem_rdata, err_flag, exp); end
`endif
    @(negedge clk);
    wait_cfg[0] = 0;
  endtask

  task automatic test_overlap;
    int lat, cyc; logic [3:0] sv; logic [31:0] exp;
    wait_cfg[1] = 2;
    drive_req(32'h0100_0040, 32'h0, 4'h0);
    sb.push_back(slv_data[1]);
    wait_resp(lat, sv, cyc);
    checks++; if (sv !== 4'b0010) begin errors++; $display("FAIL overlap_sel got %b want 0010", sv); end
    checks++; if (s_addr !== 32'h0100_0040) begin errors++; $display("FAIL overlap_s_addr got %h want 01000040", s_addr); end
    exp = sb.pop_front();
    checks++; if (lat != 4 || mem_rdata !== exp) begin errors++; $display("FAIL overlap_resp got %0d/%h want 4/%h", lat, mem_rdata, exp); end
    @(negedge clk);
    wait_cfg[1] = 0;
  endtask

  task automatic test_back_to_back;
    int lat, cyc, k, w; logic [3:0] sv; logic [31:0] exp;
    for (int n = 0; n < 8; n++) begin
      k = $urandom_range(0, 2);
      w = $urandom_range(0, 3);
      wait_cfg[k] = w;
      slv_data[k] = $urandom;
      drive_req({8'(k), 24'($urandom)}, 32'h0, 4'h0);
      sb.push_back(slv_data[k]);
      wait_resp(lat, sv, cyc);
      exp = sb.pop_front();
      checks++; if (lat != w + 2 || mem_rdata !== exp) begin errors++; $display("FAIL b2b_%0d got %0d/%h want %0d/%h", n, lat, mem_rdata, w + 2, exp); end
      @(negedge clk);
      wait_cfg[k] = 0;
    end
  endtask

  task automatic test_reset_mid;
    int lat, cyc; logic [3:0] sv; logic [31:0] exp;
    wait_cfg[0] = 50;
    drive_req(32'h0000_0300, 32'h0, 4'h0);
    @(negedge clk);
    mem_valid = 1'b0;
    @(negedge clk);
    checks++; if (s_valid !== 4'b0001) begin errors++; $display("FAIL rstmid_pre got %b want 0001", s_valid); end
    rstn = 1'b0;
    #1;
    checks++; if (s_valid !== 4'b0 || mem_ready !== 1'b0) begin errors++; $display("FAIL rstmid_drop got %b/%b want 0000/0", s_valid, mem_ready); end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    wait_cfg[0] = 0;
    slv_data[0] = 32'h5566_7788;
    @(negedge clk);
    drive_req(32'h0000_0004, 32'h0, 4'h0);
    sb.push_back(32'h5566_7788);
    wait_resp(lat, sv, cyc);
    exp = sb.pop_front();
    checks++; if (lat != 2 || mem_rdata !== exp) begin errors++; $display("FAIL rstmid_fresh got %0d/%h want 2/%h", lat, mem_rdata, exp); end
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    err_clr = 1'b0; force_rdy = '0;
    for (int i = 0; i < 4; i++) begin
      wait_cfg[i] = 0;
      wcnt[i]     = 0;
      slv_data[i] = 32'hCAFE_0000 | 32'(i);
    end
    #1;
    test_reset;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    test_read;
    test_write;
    test_unmapped;
    test_timeout;
    test_overlap;
    test_back_to_back;
    test_reset_mid;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
